// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard unit: forwarding-select encodings and the
// per-source compare result.
package hazard_ctrl_pkg;

  localparam int unsigned SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    NO_HAZARD       = 2'b00,
    HAZARD_1        = 2'b01,
    HAZARD_2        = 2'b10,
    LOAD_USE_HAZARD = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    fwd_sel_e sel;
    logic     load_use;
  } cmp_res_t;

endpackage

// File: rtl/hazard_cmp.sv
// Match and priority logic for one ID source operand against the EX and MEM
// shadow slots.
module hazard_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              re_i,
  input  logic              ex_v_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_load_i,
  input  logic              mem_v_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              lu_i,
  output cmp_res_t          res_o
);

  logic used_c;
  logic ex_hit_c;
  logic mem_hit_c;

  // x0 is hardwired, so an unused source or x0 never forwards.
  always_comb begin
    used_c    = re_i && (rs_i != '0);
    ex_hit_c  = used_c && ex_v_i && (ex_rd_i == rs_i);
    mem_hit_c = used_c && mem_v_i && (mem_rd_i == rs_i);
  end

  always_comb begin
    res_o.sel      = NO_HAZARD;
    res_o.load_use = 1'b0;
    if (ex_hit_c) begin
      if (ex_load_i) begin
        res_o.load_use = 1'b1;
      end else begin
        res_o.sel = HAZARD_1;
      end
    end else if (mem_hit_c) begin
      res_o.sel = lu_i ? LOAD_USE_HAZARD : HAZARD_2;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: shadows EX/MEM destinations, drives ID forwarding
// selects, the one-cycle load-use stall and bubble/flush control.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              ex_flush,
  output logic [SEL_W-1:0]  rD1_sel,
  output logic [SEL_W-1:0]  rD2_sel,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              ex_v_q, ex_v_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_load_q, ex_load_d;
  logic              mem_v_q, mem_v_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              lu_q, lu_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  cmp_res_t res1;
  cmp_res_t res2;
  logic     load_use_c;
  logic     stall_c;
  logic     bubble_c;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs1 (
    .rs_i      (id_rs1),
    .re_i      (id_re1),
    .ex_v_i    (ex_v_q),
    .ex_rd_i   (ex_rd_q),
    .ex_load_i (ex_load_q),
    .mem_v_i   (mem_v_q),
    .mem_rd_i  (mem_rd_q),
    .lu_i      (lu_q),
    .res_o     (res1)
  );

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs2 (
    .rs_i      (id_rs2),
    .re_i      (id_re2),
    .ex_v_i    (ex_v_q),
    .ex_rd_i   (ex_rd_q),
    .ex_load_i (ex_load_q),
    .mem_v_i   (mem_v_q),
    .mem_rd_i  (mem_rd_q),
    .lu_i      (lu_q),
    .res_o     (res2)
  );

  // A flush kills the ID instruction, so it overrides any load-use stall.
  always_comb begin
    load_use_c = res1.load_use || res2.load_use;
    stall_c    = load_use_c && !ex_flush;
    bubble_c   = load_use_c || ex_flush;
  end

  always_comb begin
    ex_v_d      = id_we && (id_rd != '0) && !bubble_c;
    ex_rd_d     = id_rd;
    ex_load_d   = id_load;
    mem_v_d     = ex_v_q;
    mem_rd_d    = ex_rd_q;
    lu_d        = stall_c;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ex_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_q      <= 1'b0;
      ex_rd_q     <= '0;
      ex_load_q   <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= '0;
      lu_q        <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_rd_q     <= ex_rd_d;
      ex_load_q   <= ex_load_d;
      mem_v_q     <= mem_v_d;
      mem_rd_q    <= mem_rd_d;
      lu_q        <= lu_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    rD1_sel     = res1.sel;
    rD2_sel     = res2.sel;
    stall_pc    = stall_c;
    stall_ifid  = stall_c;
    bubble_idex = bubble_c;
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected outputs are queued when an ID
// instruction is driven and compared at the following falling edge.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic [4:0] rs1; logic re1; logic [4:0] rs2; logic re2;
    logic [4:0] rd;  logic we;  logic ld;        logic fl;
  } in_t;

  typedef struct packed {
    logic [1:0] s1; logic [1:0] s2; logic stall; logic bub;
  } exp_t;

  typedef struct packed {
    logic [1:0] s1; logic [1:0] s2; logic spc; logic sif; logic bub;
    logic [15:0] scnt; logic [15:0] fcnt;
  } obs_t;

  logic              clk, rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_re1, id_re2, id_we, id_load, ex_flush;
  logic [1:0]        rD1_sel, rD2_sel;
  logic              stall_pc, stall_ifid, bubble_idex;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_re1      (id_re1),
    .id_re2      (id_re2),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_load     (id_load),
    .ex_flush    (ex_flush),
    .rD1_sel     (rD1_sel),
    .rD2_sel     (rD2_sel),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .bubble_idex (bubble_idex),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] e_scnt = '0;
  logic [15:0] e_fcnt = '0;
  obs_t        sb[$];
  in_t         pv[$];
  exp_t        pe[$];
  obs_t        got, want;

  function automatic in_t mk(input int rs1, input bit re1, input int rs2, input bit re2,
                             input int rd, input bit we, input bit ld, input bit fl);
    in_t v;
    v.rs1 = 5'(rs1); v.re1 = re1; v.rs2 = 5'(rs2); v.re2 = re2;
    v.rd  = 5'(rd);  v.we  = we;  v.ld  = ld;      v.fl  = fl;
    return v;
  endfunction

  function automatic exp_t mx(input logic [1:0] s1, input logic [1:0] s2,
                              input bit stall, input bit bub);
    exp_t e;
    e.s1 = s1; e.s2 = s2; e.stall = stall; e.bub = bub;
    return e;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.s1 = rD1_sel; o.s2 = rD2_sel; o.spc = stall_pc; o.sif = stall_ifid;
    o.bub = bubble_idex; o.scnt = stall_cnt; o.fcnt = flush_cnt;
    return o;
  endfunction

  task automatic apply(input in_t v);
    id_rs1 = v.rs1; id_re1 = v.re1; id_rs2 = v.rs2; id_re2 = v.re2;
    id_rd = v.rd; id_we = v.we; id_load = v.ld; ex_flush = v.fl;
  endtask

  // Expected counters reflect events of earlier cycles only.
  task automatic push_exp(input exp_t e);
    obs_t w;
    w.s1 = e.s1; w.s2 = e.s2; w.spc = e.stall; w.sif = e.stall; w.bub = e.bub;
    w.scnt = e_scnt; w.fcnt = e_fcnt;
    sb.push_back(w);
  endtask

  task automatic drive(input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    apply(v);
    push_exp(e);
    if (e.stall) e_scnt = e_scnt + 16'd1;
    if (v.fl)    e_fcnt = e_fcnt + 16'd1;
  endtask

  task automatic plan(input in_t v, input exp_t e);
    pv.push_back(v);
    pe.push_back(e);
  endtask

  task automatic plan_nops();
    plan(mk(0,0,0,0,0,0,0,0), mx(0,0,0,0));
    plan(mk(0,0,0,0,0,0,0,0), mx(0,0,0,0));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(mk(1,1,2,1,5,1,0,0));
    push_exp(mx(0,0,0,0));
    @(negedge clk);
    got = observed(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", got, want);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(mk(5,1,5,1,6,1,0,0));
    push_exp(mx(0,0,0,0));
    @(negedge clk);
    got = observed(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", got, want);
    end
  endtask

  task automatic test_back_to_back();
    pv.delete(); pe.delete();
    plan_nops();
    plan(mk(1,1,2,1,5,1,0,0), mx(2'b00,2'b00,0,0));
    plan(mk(5,1,5,1,6,1,0,0), mx(2'b01,2'b01,0,0));
    plan(mk(6,1,5,1,7,1,0,0), mx(2'b01,2'b10,0,0));
    for (int i = 0; i < pv.size(); i++) begin
      drive(pv[i], pe[i]);
      @(negedge clk);
      got = observed(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_one_gap();
    pv.delete(); pe.delete();
    plan_nops();
    plan(mk(1,1,2,1,5,1,0,0), mx(2'b00,2'b00,0,0));
    plan(mk(0,0,0,0,0,0,0,0), mx(2'b00,2'b00,0,0));
    plan(mk(0,1,5,1,7,1,0,0), mx(2'b00,2'b10,0,0));
    for (int i = 0; i < pv.size(); i++) begin
      drive(pv[i], pe[i]);
      @(negedge clk);
      got = observed(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL one_gap step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    pv.delete(); pe.delete();
    plan_nops();
    plan(mk(2,1,0,0,8,1,1,0), mx(2'b00,2'b00,0,0));
    plan(mk(8,1,1,1,9,1,0,0), mx(2'b00,2'b00,1,1));
    plan(mk(8,1,1,1,9,1,0,0), mx(2'b11,2'b00,0,0));
    plan(mk(0,0,0,0,0,0,0,0), mx(2'b00,2'b00,0,0));
    plan(mk(0,0,0,0,4,1,1,0), mx(2'b00,2'b00,0,0));
    plan(mk(4,1,4,1,10,1,0,0), mx(2'b00,2'b00,1,1));
    plan(mk(4,1,4,1,10,1,0,0), mx(2'b11,2'b11,0,0));
    plan_nops();
    plan(mk(0,0,0,0,8,1,1,0), mx(2'b00,2'b00,0,0));
    plan(mk(0,0,0,0,0,0,0,0), mx(2'b00,2'b00,0,0));
    plan(mk(8,1,0,0,9,1,0,0), mx(2'b10,2'b00,0,0));
    for (int i = 0; i < pv.size(); i++) begin
      drive(pv[i], pe[i]);
      @(negedge clk);
      got = observed(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL load_use step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_flush();
    pv.delete(); pe.delete();
    plan_nops();
    plan(mk(2,1,0,0,8,1,1,0), mx(2'b00,2'b00,0,0));
    plan(mk(8,1,1,1,9,1,0,1), mx(2'b00,2'b00,0,1));
    plan(mk(8,1,0,0,11,1,0,0), mx(2'b10,2'b00,0,0));
    plan(mk(0,0,0,0,12,1,0,1), mx(2'b00,2'b00,0,1));
    plan(mk(0,0,0,0,0,0,0,0), mx(2'b00,2'b00,0,0));
    for (int i = 0; i < pv.size(); i++) begin
      drive(pv[i], pe[i]);
      @(negedge clk);
      got = observed(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL flush step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_priority();
    pv.delete(); pe.delete();
    plan_nops();
    plan(mk(0,0,0,0,3,1,0,0), mx(2'b00,2'b00,0,0));
    plan(mk(0,0,0,0,3,1,0,0), mx(2'b00,2'b00,0,0));
    plan(mk(3,1,3,0,13,1,0,0), mx(2'b01,2'b00,0,0));
    plan(mk(0,0,0,0,3,1,0,0), mx(2'b00,2'b00,0,0));
    plan(mk(0,0,0,0,3,1,1,0), mx(2'b00,2'b00,0,0));
    plan(mk(3,1,0,0,14,1,0,0), mx(2'b00,2'b00,1,1));
    plan(mk(3,1,0,0,14,1,0,0), mx(2'b11,2'b00,0,0));
    for (int i = 0; i < pv.size(); i++) begin
      drive(pv[i], pe[i]);
      @(negedge clk);
      got = observed(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL priority step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_rst_mid_stall();
    pv.delete(); pe.delete();
    plan_nops();
    plan(mk(0,0,0,0,8,1,1,0), mx(2'b00,2'b00,0,0));
    plan(mk(8,1,0,0,9,1,0,0), mx(2'b00,2'b00,1,1));
    for (int i = 0; i < pv.size(); i++) begin
      drive(pv[i], pe[i]);
      @(negedge clk);
      got = observed(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL rst_mid_stall setup step %0d: got %h want %h", i, got, want);
      end
    end
    #1;
    rst = 1'b1;
    e_scnt = '0;
    e_fcnt = '0;
    push_exp(mx(0,0,0,0));
    #1;
    got = observed(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL rst_mid_stall async: got %h want %h", got, want);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp(mx(0,0,0,0));
    #1;
    got = observed(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL rst_mid_stall release: got %h want %h", got, want);
    end
    drive(mk(8,1,0,0,9,1,0,0), mx(2'b00,2'b00,0,0));
    @(negedge clk);
    got = observed(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL rst_mid_stall after: got %h want %h", got, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    apply(mk(0,0,0,0,0,0,0,0));
    test_reset();
    test_back_to_back();
    test_one_gap();
    test_load_use();
    test_flush();
    test_priority();
    test_rst_mid_stall();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
